// File: rtl/button_counter_pkg.sv
// Shared constants and helpers for the button counter.
// Debounce filter sizing and the electrical "released" level of a raw button.
package button_counter_pkg;

    // Raw buttons are active-low, so an idle button reads 1.
    localparam logic RELEASED = 1'b1;

    // Filter counter width.
    // The counter must hold values up to DEBOUNCE_CYCLES-1.
    // clog2(cycles+1) covers that and never returns 0 for cycles >= 1.
    function automatic int filt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, consecutive-cycle filter,
// debounced stable level and a single-cycle press pulse.
// The press pulse fires on the same edge on which the stable level flips to
// pressed, so the consumer can act on it without any further delay.
module button_debounce
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int              CW   = filt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] filt;
    logic          differ;
    logic          flip;

    // The filter counts edges on which the synchronised level disagrees with
    // the stable one. The stable level flips on the DEBOUNCE_CYCLES-th such
    // edge in a row.
    assign differ = (sync2 != stable);
    assign flip   = differ && (filt == LAST);

    // Two-flop synchroniser for the asynchronous raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // Filter counter and stable level; any agreeing cycle restarts the filter
    always_ff @(posedge clk) begin
        if (rst) begin
            filt   <= '0;
            stable <= RELEASED;
        end else if (!differ) begin
            filt   <= '0;
        end else if (flip) begin
            filt   <= '0;
            stable <= sync2;
        end else begin
            filt   <= filt + CW'(1);
        end
    end

    assign level = (stable != RELEASED);
    assign press = flip && (sync2 != RELEASED);

endmodule

// File: rtl/button_counter.sv
// Debounced button event counter.
// Up presses increment and, when BUTTON_COUNTER_DOWN_EN is defined, down
// presses decrement. WRAP selects modulo or saturating behaviour. limit
// pulses for one cycle on the edge where the count wraps or is held at a
// bound.
// Without BUTTON_COUNTER_DOWN_EN the btn_dn_n port exists but is ignored.
module button_counter
    import button_counter_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WRAP            = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up_n,
    input  logic             btn_dn_n,
    output logic [WIDTH-1:0] count,
    output logic             up_held,
    output logic             limit
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic             up_level;
    logic             up_press;
    logic             dn_press;
    logic [WIDTH-1:0] count_nxt;
    logic             limit_nxt;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_up_n),
        .level (up_level),
        .press (up_press)
    );

`ifdef BUTTON_COUNTER_DOWN_EN
    logic dn_level_unused;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_dn_n),
        .level (dn_level_unused),
        .press (dn_press)
    );
`else
    logic dn_unused;

    assign dn_unused = btn_dn_n;
    assign dn_press  = 1'b0;
`endif

    // The stable level is already a flop output, so up_held stays aligned
    // with the count update.
    assign up_held = up_level;

    // Next count: simultaneous up and down presses cancel
    always_comb begin
        count_nxt = count;
        limit_nxt = 1'b0;
        case ({up_press, dn_press})
            2'b10: begin
                if (count == MAX_VAL) begin
                    limit_nxt = 1'b1;
                    count_nxt = (WRAP != 0) ? '0 : count;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end
            2'b01: begin
                if (count == '0) begin
                    limit_nxt = 1'b1;
                    count_nxt = (WRAP != 0) ? MAX_VAL : count;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered count and limit pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            limit <= 1'b0;
        end else begin
            count <= count_nxt;
            limit <= limit_nxt;
        end
    end

endmodule

// File: tb/tb_button_counter.sv
// Self-checking bench for button_counter (DEBOUNCE_CYCLES=4, WIDTH=4).
// One instance uses WRAP=1 and a second uses WRAP=0, both fed the same
// buttons. Down-channel checks follow BUTTON_COUNTER_DOWN_EN.
module tb_button_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_n;
    logic       dn_n;
    logic [3:0] count_w;
    logic       held_w;
    logic       limit_w;
    logic [3:0] count_s;
    logic       held_s;
    logic       limit_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .WRAP(1)) dut (
        .clk (clk), .rst (rst), .btn_up_n (up_n), .btn_dn_n (dn_n),
        .count (count_w), .up_held (held_w), .limit (limit_w)
    );

    button_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .WRAP(0)) dut_sat (
        .clk (clk), .rst (rst), .btn_up_n (up_n), .btn_dn_n (dn_n),
        .count (count_s), .up_held (held_s), .limit (limit_s)
    );

    typedef struct {
        logic       rst;
        logic       up_n;
        logic       dn_n;
        logic [3:0] cnt;
        logic       held;
        logic       lim;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic u, input logic d,
                       input logic [3:0] c, input logic h, input logic l);
        vec_t v;
        v.rst = r; v.up_n = u; v.dn_n = d; v.cnt = c; v.held = h; v.lim = l;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; up_n = 1'b1; dn_n = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int lim_w_seen;
    int lim_s_seen;

    initial begin
        rst = 1'b1; up_n = 1'b1; dn_n = 1'b1;

        // Reset, then a 20-cycle hold: count changes only on the 6th edge
        add(1, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0);
        for (int i = 7; i <= 20; i++) add(0, 0, 1, 1, 1, 0);
        // Release: the level drops on the 6th edge, and the count is untouched
        for (int i = 1; i <= 5; i++) add(0, 1, 1, 1, 1, 0);
        for (int i = 6; i <= 8; i++) add(0, 1, 1, 1, 0, 0);
        // Reset, then bounce low 3 / high 3 / low 3: this must be rejected
        add(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 0, 0);

        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; up_n = vecs[i].up_n; dn_n = vecs[i].dn_n;
            step();
            chk($sformatf("vec%0d count", i), count_w, vecs[i].cnt);
            chk($sformatf("vec%0d up_held", i), held_w, vecs[i].held);
            chk($sformatf("vec%0d limit", i), limit_w, vecs[i].lim);
        end

        // 16 clean presses: wrap vs saturate at the top
        do_reset();
        lim_w_seen = 0;
        lim_s_seen = 0;
        for (int p = 1; p <= 16; p++) begin
            up_n = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                step();
                lim_w_seen += int'(limit_w);
                lim_s_seen += int'(limit_s);
            end
            chk($sformatf("press%0d wrap count", p), count_w, p % 16);
            chk($sformatf("press%0d wrap limit", p), limit_w, (p == 16) ? 1 : 0);
            chk($sformatf("press%0d sat count", p), count_s, (p > 15) ? 15 : p);
            chk($sformatf("press%0d sat limit", p), limit_s, (p == 16) ? 1 : 0);
            up_n = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                step();
                lim_w_seen += int'(limit_w);
                lim_s_seen += int'(limit_s);
            end
        end
        chk("wrap limit pulse count", lim_w_seen, 1);
        chk("sat limit pulse count", lim_s_seen, 1);

        // Reset on edges 4 and 5 of a held press; full latency restarts at edge 6
        do_reset();
        up_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            rst = (e == 4 || e == 5) ? 1'b1 : 1'b0;
            step();
            chk($sformatf("rst-mid e%0d count", e), count_w, (e >= 11) ? 1 : 0);
            chk($sformatf("rst-mid e%0d held", e), held_s, (e >= 11) ? 1 : 0);
        end
        rst = 1'b0;
        up_n = 1'b1;
        for (int k = 0; k < 6; k++) step();

`ifdef BUTTON_COUNTER_DOWN_EN
        // Five ups, then both buttons at once: the two presses cancel
        do_reset();
        for (int p = 1; p <= 5; p++) begin
            up_n = 1'b0;
            for (int k = 0; k < 6; k++) step();
            up_n = 1'b1;
            for (int k = 0; k < 6; k++) step();
        end
        chk("pre-cancel count", count_w, 5);
        up_n = 1'b0; dn_n = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("cancel count", count_w, 5);
        chk("cancel limit", limit_w, 0);
        chk("cancel held", held_w, 1);
        up_n = 1'b1; dn_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        // Down alone from 0
        do_reset();
        dn_n = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("down wrap count", count_w, 15);
        chk("down wrap limit", limit_w, 1);
        chk("down sat count", count_s, 0);
        chk("down sat limit", limit_s, 1);
        step();
        chk("down wrap limit drop", limit_w, 0);
        dn_n = 1'b1;
`else
        // The down button is ignored in an up-only build
        do_reset();
        for (int p = 1; p <= 5; p++) begin
            dn_n = 1'b0;
            for (int k = 0; k < 6; k++) step();
            chk($sformatf("dn-ignored %0d count", p), count_w, 0);
            chk($sformatf("dn-ignored %0d limit", p), limit_w, 0);
            dn_n = 1'b1;
            for (int k = 0; k < 6; k++) step();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
